rf_wb_arbiter: RTL and testbench

- Write-back stage directly upstream of the register file. It drives the file's single write port (`wen`/`waddr`/`wdata`).
- Merges two result producers:
  - ALU results: one per cycle, always accepted, highest priority.
  - Memory-load results: valid/ready handshake, buffered in a small in-order FIFO.
- Also reports read-after-write hazards for the two register-file read addresses, so the issue logic can stall.

---
 rtl/rf_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: merges ALU results (priority) with buffered load results
// onto the single register-file write port, and flags pending-write hazards.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  input  logic [ADDR_WIDTH-1:0]           alu_waddr,
  input  logic [DATA_WIDTH-1:0]           alu_wdata,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [ADDR_WIDTH-1:0]           mem_waddr,
  input  logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [ADDR_WIDTH-1:0]           raddr1,
  input  logic [ADDR_WIDTH-1:0]           raddr2,
  output logic                            hazard1,
  output logic                            hazard2,
  output logic                            wen,
  output logic [ADDR_WIDTH-1:0]           waddr,
  output logic [DATA_WIDTH-1:0]           wdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  push, pop;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [FIFO_DEPTH-1:0] occ;
  logic [PTR_W-1:0]      off;
  logic                  hit1, hit2;

  // Ready depends only on registered occupancy, so a full FIFO never
  // accepts even when it pops in the same cycle.
  assign mem_ready = (count_q != CNT_W'(FIFO_DEPTH));
  // Loads to r0 complete the handshake but are dropped.
  assign push      = mem_valid && mem_ready && (mem_waddr != '0);
  assign pop       = !alu_valid && (count_q != '0);

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_addr  = alu_waddr;
      sel_data  = alu_wdata;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_addr  = fifo_addr_q[rd_ptr_q];
      sel_data  = fifo_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = mem_waddr;
      fifo_data_d[wr_ptr_q] = mem_wdata;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output register holds address/data when idle; only wen drops.
  always_comb begin
    wen_d   = sel_valid && (sel_addr != '0);
    waddr_d = sel_valid ? sel_addr : waddr_q;
    wdata_d = sel_valid ? sel_data : wdata_q;
  end

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    occ  = '0;
    off  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off    = PTR_W'(i) - rd_ptr_q;
      occ[i] = ({1'b0, off} < count_q);
      if (occ[i] && (fifo_addr_q[i] == raddr1)) hit1 = 1'b1;
      if (occ[i] && (fifo_addr_q[i] == raddr2)) hit2 = 1'b1;
    end
    if (wen_q && (waddr_q == raddr1)) hit1 = 1'b1;
    if (wen_q && (waddr_q == raddr2)) hit2 = 1'b1;
  end

  assign hazard1 = (raddr1 != '0) && hit1;
  assign hazard2 = (raddr2 != '0) && hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: fixed stimulus steps with hand-computed results.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hazard1;
  logic        hazard2;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .wen(wen), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0; raddr1 = '0; raddr2 = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);

    // Single ALU write, one-cycle latency
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk("alu_wen", 32'(wen), 32'd1);
    chk("alu_waddr", 32'(waddr), 32'd3);
    chk("alu_wdata", wdata, 32'hDEADBEEF);
    step();
    chk("alu_wen_drop", 32'(wen), 32'd0);
    chk("alu_waddr_hold", 32'(waddr), 32'd3);

    // Fill the FIFO while the ALU starves it
    alu_valid = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'h0;
    mem_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      mem_waddr = 5'(k); mem_wdata = 32'h10 + 32'(k);
      step();
    end
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_ready", 32'(mem_ready), 32'd0);
    mem_waddr = 5'd5; mem_wdata = 32'h15;
    step();
    chk("stall_count", 32'(fifo_count), 32'd4);
    chk("stall_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    chk("drain1_wen", 32'(wen), 32'd1);
    chk("drain1_waddr", 32'(waddr), 32'd1);
    chk("drain1_wdata", wdata, 32'h11);
    chk("drain1_ready", 32'(mem_ready), 32'd1);
    chk("drain1_count", 32'(fifo_count), 32'd3);
    step();
    chk("drain2_waddr", 32'(waddr), 32'd2);
    chk("drain2_wdata", wdata, 32'h12);
    step();
    chk("drain3_waddr", 32'(waddr), 32'd3);
    chk("drain3_wdata", wdata, 32'h13);
    step();
    chk("drain4_wen", 32'(wen), 32'd1);
    chk("drain4_waddr", 32'(waddr), 32'd4);
    chk("drain4_wdata", wdata, 32'h14);
    step();
    chk("drain_idle_wen", 32'(wen), 32'd0);
    chk("drain_idle_count", 32'(fifo_count), 32'd0);

    // Hazard from a buffered load, none for r0
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h1234;
    mem_valid = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h77;
    step();
    mem_valid = 1'b0; raddr1 = 5'd7; raddr2 = 5'd0;
    #1;
    chk("haz_buf_h1", 32'(hazard1), 32'd1);
    chk("haz_r0_h2", 32'(hazard2), 32'd0);
    chk("haz_r0_wen", 32'(wen), 32'd0);
    alu_valid = 1'b0;
    step();
    chk("haz_wen7", 32'(wen), 32'd1);
    chk("haz_waddr7", 32'(waddr), 32'd7);
    chk("haz_out_h1", 32'(hazard1), 32'd1);
    step();
    chk("haz_clear_h1", 32'(hazard1), 32'd0);
    raddr1 = 5'd0;

    // Writes to r0 from both sources are suppressed
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFF;
    mem_valid = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'hEEEE;
    step();
    chk("r0_wen_a", 32'(wen), 32'd0);
    chk("r0_count_a", 32'(fifo_count), 32'd0);
    alu_valid = 1'b0;
    step();
    chk("r0_wen_b", 32'(wen), 32'd0);
    chk("r0_count_b", 32'(fifo_count), 32'd0);

    // Simultaneous push and pop at count 2
    alu_valid = 1'b1; alu_waddr = 5'd0;
    mem_valid = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'h55;
    step();
    mem_waddr = 5'd6; mem_wdata = 32'h66;
    step();
    chk("pp_pre_count", 32'(fifo_count), 32'd2);
    alu_valid = 1'b0; mem_waddr = 5'd9; mem_wdata = 32'h99;
    step();
    mem_valid = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd2);
    chk("pp_waddr5", 32'(waddr), 32'd5);
    chk("pp_wdata5", wdata, 32'h55);
    step();
    chk("pp_waddr6", 32'(waddr), 32'd6);
    chk("pp_count1", 32'(fifo_count), 32'd1);
    step();
    chk("pp_wen9", 32'(wen), 32'd1);
    chk("pp_waddr9", 32'(waddr), 32'd9);
    chk("pp_wdata9", wdata, 32'h99);
    step();
    chk("pp_idle_wen", 32'(wen), 32'd0);

    // Reset with loads buffered and a write pending
    alu_valid = 1'b1; alu_waddr = 5'd0; mem_valid = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      mem_waddr = 5'(k); mem_wdata = 32'(k);
      step();
    end
    mem_valid = 1'b0; alu_waddr = 5'd20; alu_wdata = 32'hABC;
    step();
    alu_valid = 1'b0; raddr1 = 5'd11; raddr2 = 5'd20;
    #1;
    chk("prerst_wen", 32'(wen), 32'd1);
    chk("prerst_count", 32'(fifo_count), 32'd3);
    chk("prerst_h1", 32'(hazard1), 32'd1);
    chk("prerst_h2", 32'(hazard2), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_wen", 32'(wen), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_waddr", 32'(waddr), 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    chk("midrst_h1", 32'(hazard1), 32'd0);
    chk("midrst_h2", 32'(hazard2), 32'd0);
    chk("midrst_ready", 32'(mem_ready), 32'd1);
    step();
    chk("postrst_wen_a", 32'(wen), 32'd0);
    step();
    chk("postrst_wen_b", 32'(wen), 32'd0);
    chk("postrst_count", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
